pixel_plotter: RTL and testbench

// Read-modify-write painter between the camera coordinate path and the sram controller.
// - Latches the latest camera (x,y) and, once per frame in the vblank window, sets that single pixel in the 1bpp SRAM frame buffer.
// - Sets the pixel by reading its 16-bit word, OR-ing in the bit and writing the word back.
// - Also performs a full-buffer erase on request.
// - Replaces the blind whole-word write of the current SRAM state machine; the line-buffer read path is unchanged.

---
 rtl/pixel_plotter_if.sv | 22 ++
 rtl/pixel_plotter.sv | 158 +++++++++++++++
 tb/tb_pixel_plotter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_plotter_if.sv
// SRAM controller request/response bus seen by the pixel plotter.
// The plotter is the master; the SRAM controller is the slave.
interface pixel_plotter_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [ADDR_W-1:0] address;
  logic [15:0]       data_write;
  logic [15:0]       data_read;
  logic              read;
  logic              write;
  logic              ready;

  modport master (
    output address, data_write, read, write,
    input  data_read, ready
  );

  modport slave (
    input  address, data_write, read, write,
    output data_read, ready
  );
endinterface

// File: rtl/pixel_plotter.sv
// Read-modify-write pixel painter for a 1bpp SRAM frame buffer: sets the latest camera
// pixel once per vblank, or clears the whole buffer on request.
module pixel_plotter #(
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned LINE_WORDS = 40,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             plot_x,
  input  logic [9:0]             plot_y,
  input  logic                   plot_valid,
  input  logic                   frame_start,
  input  logic                   erase_req,
  output logic                   busy,
  output logic                   done,
  pixel_plotter_if.master        sram
);

  localparam logic [9:0]        HLimit   = 10'(H_PIXELS);
  localparam logic [9:0]        VLimit   = 10'(V_LINES);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(V_LINES * LINE_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle, StRd, StRdWait, StWr, StWrWait, StEr, StErWait, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        px_q, px_d, py_q, py_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       mask_q, mask_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              done_q, done_d;

  logic              sample_ok;
  logic              start_plot;
  logic [ADDR_W-1:0] plot_addr;

  assign sample_ok  = plot_valid && (plot_x < HLimit) && (plot_y < VLimit);
  assign start_plot = (state_q == StIdle) && frame_start && !erase_req && pending_q;
  // py*40 built from shifts: 40 = 32 + 8
  assign plot_addr  = (ADDR_W'(py_q) << 5) + (ADDR_W'(py_q) << 3) + ADDR_W'(px_q[9:4]);

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    read_d    = read_q;
    write_d   = write_q;
    done_d    = 1'b0;

    // Clear before capture so a sample arriving on the launch cycle stays pending
    if (start_plot) pending_d = 1'b0;
    if (sample_ok) begin
      px_d      = plot_x;
      py_d      = plot_y;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          if (erase_req) begin
            state_d = StEr;
            addr_d  = '0;
          end else if (pending_q) begin
            state_d = StRd;
            addr_d  = plot_addr;
            mask_d  = 16'h1 << px_q[3:0];
          end
        end
      end
      StRd: begin
        read_d  = 1'b1;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (sram.ready) begin
          read_d  = 1'b0;
          wdata_d = sram.data_read | mask_q;
          state_d = StWr;
        end
      end
      StWr: begin
        write_d = 1'b1;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (sram.ready) begin
          write_d = 1'b0;
          state_d = StFin;
        end
      end
      StEr: begin
        write_d = 1'b1;
        wdata_d = 16'h0000;
        state_d = StErWait;
      end
      StErWait: begin
        if (sram.ready) begin
          write_d = 1'b0;
          if (addr_q == LastAddr) begin
            state_d = StFin;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StEr;
          end
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      px_q      <= '0;
      py_q      <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      read_q    <= read_d;
      write_q   <= write_d;
      done_q    <= done_d;
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign sram.address    = addr_q;
  assign sram.data_write = wdata_q;
  assign sram.read       = read_q;
  assign sram.write      = write_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed bench for pixel_plotter: a small SRAM responder acks every request one cycle
// later and logs it; the main sequence checks the logged traffic against hand values.
module tb_pixel_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] plot_x = '0;
  logic [9:0] plot_y = '0;
  logic       plot_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       erase_req = 1'b0;
  logic       busy;
  logic       done;

  pixel_plotter_if #(.ADDR_W(18)) bus ();

  pixel_plotter #(
    .H_PIXELS  (640),
    .V_LINES   (480),
    .LINE_WORDS(40),
    .ADDR_W    (18)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_valid (plot_valid),
    .frame_start(frame_start),
    .erase_req  (erase_req),
    .busy       (busy),
    .done       (done),
    .sram       (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Responder and monitor state
  logic [15:0] rd_data = '0;
  logic        hold = 1'b0;
  logic        erase_mode = 1'b0;
  int unsigned n_reads, n_writes, n_done, erase_bad, overlap, er_next;
  logic [17:0] last_rd_addr, last_wr_addr;
  logic [15:0] last_wr_data;
  logic        busy_seen;

  initial begin
    bus.ready     = 1'b0;
    bus.data_read = '0;
  end

  always @(posedge clk) begin
    #1;
    if (bus.ready) begin
      bus.ready = 1'b0;
    end else if (!hold && (bus.read || bus.write)) begin
      bus.ready = 1'b1;
      if (bus.read) begin
        n_reads++;
        last_rd_addr  = bus.address;
        bus.data_read = rd_data;
      end else begin
        n_writes++;
        last_wr_addr = bus.address;
        last_wr_data = bus.data_write;
        if (erase_mode) begin
          if (bus.address != 18'(er_next) || bus.data_write != 16'h0000) erase_bad++;
          er_next++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) n_done++;
    if (busy) busy_seen = 1'b1;
    if (bus.read && bus.write) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    n_reads = 0; n_writes = 0; n_done = 0; erase_bad = 0; er_next = 0;
    last_rd_addr = '1; last_wr_addr = '1; last_wr_data = 'x;
    busy_seen = 1'b0;
  endtask

  task automatic plot(input int x, input int y);
    @(negedge clk);
    plot_x = 10'(x); plot_y = 10'(y); plot_valid = 1'b1;
    @(negedge clk);
    plot_valid = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    overlap = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_read",  {31'd0, bus.read}, 32'd0);
    chk("rst_write", {31'd0, bus.write}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_addr",  32'(bus.address), 32'd0);
    chk("rst_wdata", 32'(bus.data_write), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // (17,2): word 2*40+1 = 81, bit 1
    clear_stats();
    rd_data = 16'h0000;
    plot(17, 2);
    frame();
    chk("p1_read_lag", {31'd0, bus.read}, 32'd0);
    chk("p1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("p1_read_up", {31'd0, bus.read}, 32'd1);
    chk("p1_rd_addr_live", 32'(bus.address), 32'd81);
    wait_done("p1_done", 20);
    chk("p1_nreads", n_reads, 1);
    chk("p1_rd_addr", 32'(last_rd_addr), 32'd81);
    chk("p1_nwrites", n_writes, 1);
    chk("p1_wr_addr", 32'(last_wr_addr), 32'd81);
    chk("p1_wr_data", 32'(last_wr_data), 32'h0002);
    chk("p1_ndone", n_done, 1);
    chk("p1_busy_after", {31'd0, busy}, 32'd0);

    // (31,0): word 1, bit 15 already set
    clear_stats();
    rd_data = 16'h8001;
    plot(31, 0);
    frame();
    wait_done("p2_done", 20);
    chk("p2_wr_addr", 32'(last_wr_addr), 32'd1);
    chk("p2_wr_data", 32'(last_wr_data), 32'h8001);

    // x=640 is off-screen and must be dropped
    clear_stats();
    plot(640, 10);
    frame();
    repeat (10) @(negedge clk);
    chk("oor_nreads", n_reads, 0);
    chk("oor_nwrites", n_writes, 0);
    chk("oor_busy", {31'd0, busy_seen}, 32'd0);

    // Latest wins: (600,479) -> 479*40+37 = 19197, bit 8
    clear_stats();
    rd_data = 16'h0000;
    plot(5, 5);
    plot(600, 479);
    frame();
    wait_done("lw_done", 20);
    chk("lw_nreads", n_reads, 1);
    chk("lw_rd_addr", 32'(last_rd_addr), 32'd19197);
    chk("lw_wr_addr", 32'(last_wr_addr), 32'd19197);
    chk("lw_wr_data", 32'(last_wr_data), 32'h0100);

    // Erase takes priority over a pending plot, which runs next frame
    clear_stats();
    plot(17, 2);
    erase_mode = 1'b1;
    erase_req  = 1'b1;
    frame();
    erase_req = 1'b0;
    wait_done("er_done", 60000);
    erase_mode = 1'b0;
    chk("er_nwrites", n_writes, 19200);
    chk("er_bad", erase_bad, 0);
    chk("er_last", 32'(last_wr_addr), 32'd19199);
    chk("er_nreads", n_reads, 0);
    chk("er_ndone", n_done, 1);
    clear_stats();
    rd_data = 16'h0000;
    frame();
    wait_done("er_plot_done", 20);
    chk("er_plot_addr", 32'(last_wr_addr), 32'd81);
    chk("er_plot_data", 32'(last_wr_data), 32'h0002);

    // Reset while stalled in the read wait
    clear_stats();
    hold = 1'b1;
    plot(3, 3);
    frame();
    @(negedge clk);
    chk("rs_read_up", {31'd0, bus.read}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_read", {31'd0, bus.read}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    clear_stats();
    frame();
    repeat (10) @(negedge clk);
    chk("rs_nreads", n_reads, 0);
    chk("rs_busy_after", {31'd0, busy_seen}, 32'd0);

    chk("rw_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
